// File: rtl/sub_lectura_hs_pkg.sv
// Shared types and operand-formatting helpers for the Booth operand-read stage.
package booth_pkg;
  localparam int ANCHO_DEF = 4;
  localparam int PROF_DEF  = 2;
  // Helpers work on a wide container; callers cast the result to their real width.
  localparam int MAXW      = 64;
  localparam int IW        = $clog2(MAXW);

  typedef struct packed {
    logic [ANCHO_DEF:0]   m;
    logic [ANCHO_DEF+1:0] q;
    logic                 sgn;
  } entry_t;

  // Extend a w-bit operand by one bit (sign or zero); bits above w are filled too.
  function automatic logic [MAXW:0] ext_m(input logic [MAXW-1:0] a, input int w,
                                          input logic sgn);
    logic [MAXW:0] mask;
    mask = {(MAXW+1){1'b1}} << w;
    return (sgn && a[IW'(w-1)]) ? ({1'b0, a} | mask) : {1'b0, a};
  endfunction

  // Extended multiplier with the Q(-1) bit appended as zero.
  function automatic logic [MAXW+1:0] ext_q(input logic [MAXW-1:0] b, input int w,
                                            input logic sgn);
    return {ext_m(b, w, sgn), 1'b0};
  endfunction
endpackage

// File: rtl/sub_lectura_hs_if.sv
// Handshake bus between the operand source, the read stage and the Booth core.
interface sub_lectura_hs_if #(parameter int ANCHO = 4, parameter int PROF = 2);
  logic                       in_valid;
  logic                       in_ready;
  logic [ANCHO-1:0]           in_a;
  logic [ANCHO-1:0]           in_b;
  logic                       in_signed;
  logic                       out_valid;
  logic                       out_ready;
  logic [ANCHO:0]             out_m;
  logic [ANCHO+1:0]           out_q;
  logic                       out_signed;
  logic [$clog2(PROF+1)-1:0]  count;

  modport slave (
    input  in_valid, in_a, in_b, in_signed, out_ready,
    output in_ready, out_valid, out_m, out_q, out_signed, count
  );
  modport master (
    output in_valid, in_a, in_b, in_signed, out_ready,
    input  in_ready, out_valid, out_m, out_q, out_signed, count
  );
endinterface

// File: rtl/sub_lectura_hs_fifo.sv
// Circular entry buffer with occupancy count; any depth, pointers wrap at PROF-1.
module fifo_lectura #(
  parameter int  PROF = 2,
  parameter type T    = booth_pkg::entry_t
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_push,
  input  logic                      i_pop,
  input  T                          i_data,
  output T                          o_data,
  output logic [$clog2(PROF+1)-1:0] o_count,
  output logic                      o_full,
  output logic                      o_empty
);
  localparam int CW = $clog2(PROF+1);
  localparam int PW = (PROF > 1) ? $clog2(PROF) : 1;

  T              r_mem [PROF];
  logic [PW-1:0] r_wr, r_rd, w_last;
  logic [CW-1:0] r_count;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(PROF-1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      for (int i = 0; i < PROF; i++) r_mem[i] <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= nxt(r_wr);
      end
      if (i_pop) r_rd <= nxt(r_rd);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  // While empty, show the slot just behind the read pointer so outputs hold the last entry.
  assign w_last  = (r_rd == '0) ? PW'(PROF-1) : r_rd - 1'b1;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(PROF));
  assign o_count = r_count;
  assign o_data  = o_empty ? r_mem[w_last] : r_mem[r_rd];
endmodule

// File: rtl/sub_lectura_hs.sv
// Operand-read stage: formats multiplicand/multiplier at push and queues them for the Booth core.
module sub_lectura_hs
  import booth_pkg::*;
#(
  parameter int ANCHO = ANCHO_DEF,
  parameter int PROF  = PROF_DEF
) (
  input logic              clk,
  input logic              rst,
  sub_lectura_hs_if.slave  bus
);
  typedef struct packed {
    logic [ANCHO:0]   m;
    logic [ANCHO+1:0] q;
    logic             sgn;
  } ent_t;

  ent_t                      w_in, w_head;
  logic                      w_push, w_pop, w_full, w_empty;
  logic [$clog2(PROF+1)-1:0] w_count;

  always_comb begin
    w_in     = '0;
    w_in.m   = (ANCHO+1)'(ext_m(MAXW'(bus.in_a), ANCHO, bus.in_signed));
    w_in.q   = (ANCHO+2)'(ext_q(MAXW'(bus.in_b), ANCHO, bus.in_signed));
    w_in.sgn = bus.in_signed;
  end

  // in_ready is purely occupancy based, so a full buffer never takes a push even on a pop cycle.
  assign w_push = bus.in_valid && !w_full;
  assign w_pop  = !w_empty && bus.out_ready;

  fifo_lectura #(.PROF(PROF), .T(ent_t)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_in),
    .o_data  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.in_ready   = !w_full;
  assign bus.out_valid  = !w_empty;
  assign bus.out_m      = w_head.m;
  assign bus.out_q      = w_head.q;
  assign bus.out_signed = w_head.sgn;
  assign bus.count      = w_count;
endmodule

// File: tb/tb_sub_lectura_hs.sv
// Directed checks of the operand-read stage: formatting, backpressure, wrap, async reset.
module tb_sub_lectura_hs;
  localparam int ANCHO = 4;
  localparam int PROF  = 2;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  sub_lectura_hs_if #(.ANCHO(ANCHO), .PROF(PROF)) bus ();

  sub_lectura_hs #(.ANCHO(ANCHO), .PROF(PROF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b, input logic s);
    bus.in_valid  = v;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_signed = s;
  endtask

  initial begin
    logic [3:0] ka, kb;
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 4'h0, 4'h0, 1'b0);

    // reset state
    #3;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_out_m", 32'(bus.out_m), 32'd0);
    chk("rst_out_q", 32'(bus.out_q), 32'd0);
    chk("rst_out_signed", 32'(bus.out_signed), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // 1: signed push a=1101 b=0011
    drive(1'b1, 4'b1101, 4'b0011, 1'b1);
    tick();
    drive(1'b0, 4'h0, 4'h0, 1'b0);
    chk("t1_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_m", 32'(bus.out_m), 32'b11101);
    chk("t1_q", 32'(bus.out_q), 32'b000110);
    chk("t1_sgn", 32'(bus.out_signed), 32'd1);
    chk("t1_count", 32'(bus.count), 32'd1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("t1_drain_valid", 32'(bus.out_valid), 32'd0);
    chk("t1_drain_count", 32'(bus.count), 32'd0);

    // 2: same operands unsigned then signed
    drive(1'b1, 4'b1101, 4'b1101, 1'b0);
    tick();
    drive(1'b1, 4'b1101, 4'b1101, 1'b1);
    tick();
    drive(1'b0, 4'h0, 4'h0, 1'b0);
    chk("t2_count_full", 32'(bus.count), 32'd2);
    chk("t2_in_ready_full", 32'(bus.in_ready), 32'd0);
    chk("t2u_m", 32'(bus.out_m), 32'b01101);
    chk("t2u_q", 32'(bus.out_q), 32'b011010);
    chk("t2u_sgn", 32'(bus.out_signed), 32'd0);
    bus.out_ready = 1'b1;
    tick();
    chk("t2s_m", 32'(bus.out_m), 32'b11101);
    chk("t2s_q", 32'(bus.out_q), 32'b111010);
    chk("t2s_sgn", 32'(bus.out_signed), 32'd1);
    chk("t2s_count", 32'(bus.count), 32'd1);
    tick();
    bus.out_ready = 1'b0;
    chk("t2_empty", 32'(bus.out_valid), 32'd0);

    // 3: backpressure, third pair held until after the first pop
    drive(1'b1, 4'd1, 4'd2, 1'b0);
    tick();
    drive(1'b1, 4'd3, 4'd4, 1'b0);
    tick();
    chk("t3_count2", 32'(bus.count), 32'd2);
    chk("t3_in_ready0", 32'(bus.in_ready), 32'd0);
    drive(1'b1, 4'd5, 4'd6, 1'b0);
    tick();
    chk("t3_held_count", 32'(bus.count), 32'd2);
    chk("t3_held_head", 32'(bus.out_m), 32'd1);
    bus.out_ready = 1'b1;
    tick();
    chk("t3_pop1_count", 32'(bus.count), 32'd1);
    chk("t3_pop1_head", 32'(bus.out_m), 32'd3);
    chk("t3_pop1_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    chk("t3_pop2_count", 32'(bus.count), 32'd1);
    chk("t3_pop2_m", 32'(bus.out_m), 32'd5);
    chk("t3_pop2_q", 32'(bus.out_q), 32'h0C);
    drive(1'b0, 4'h0, 4'h0, 1'b0);
    tick();
    bus.out_ready = 1'b0;
    chk("t3_empty_count", 32'(bus.count), 32'd0);

    // 4: steady push+pop at count=1 across several pointer wraps
    drive(1'b1, 4'd0, 4'hF, 1'b0);
    tick();
    chk("t4_prime_count", 32'(bus.count), 32'd1);
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      ka = 4'(k);
      kb = ~ka;
      drive(1'b1, ka, kb, 1'b0);
      tick();
      chk($sformatf("t4_count_%0d", k), 32'(bus.count), 32'd1);
      chk($sformatf("t4_m_%0d", k), 32'(bus.out_m), 32'({1'b0, ka}));
      chk($sformatf("t4_q_%0d", k), 32'(bus.out_q), 32'({1'b0, kb, 1'b0}));
    end
    drive(1'b0, 4'h0, 4'h0, 1'b0);
    tick();
    bus.out_ready = 1'b0;
    chk("t4_drained", 32'(bus.count), 32'd0);

    // 5: asynchronous reset with two entries buffered
    drive(1'b1, 4'd9, 4'd9, 1'b0);
    tick();
    tick();
    drive(1'b0, 4'h0, 4'h0, 1'b0);
    chk("t5_pre_count", 32'(bus.count), 32'd2);
    #2;
    rst = 1'b0;
    #1;
    chk("t5_async_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_async_count", 32'(bus.count), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rel_in_ready", 32'(bus.in_ready), 32'd1);
    drive(1'b1, 4'b0111, 4'b0001, 1'b1);
    tick();
    drive(1'b0, 4'h0, 4'h0, 1'b0);
    chk("t5_push_valid", 32'(bus.out_valid), 32'd1);
    chk("t5_push_count", 32'(bus.count), 32'd1);
    chk("t5_push_m", 32'(bus.out_m), 32'b00111);
    chk("t5_push_q", 32'(bus.out_q), 32'b000010);
    bus.out_ready = 1'b1;
    tick();
    chk("t5_drained", 32'(bus.count), 32'd0);

    // 6: single push into empty FIFO with out_ready held high
    drive(1'b1, 4'b1000, 4'b1000, 1'b1);
    tick();
    drive(1'b0, 4'h0, 4'h0, 1'b0);
    chk("t6_pulse_valid", 32'(bus.out_valid), 32'd1);
    chk("t6_pulse_count", 32'(bus.count), 32'd1);
    chk("t6_m", 32'(bus.out_m), 32'b11000);
    chk("t6_q", 32'(bus.out_q), 32'b110000);
    tick();
    chk("t6_after_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_after_count", 32'(bus.count), 32'd0);
    tick();
    chk("t6_stay_valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
